flow_ctrl_fsm: RTL
==================

# flow_ctrl_fsm

Parametrised control FSM for the FIFO flow-control path. It latches per-FIFO low/high watermark thresholds during an init window and validates them. It then tracks idle/active/error operation over NUM_FIFOS FIFOs and generates registered almost-empty/almost-full flags per FIFO from live occupancy. It sits beside the FIFO bank and feeds status to the arbiter and the top-level status pins.

## Interface
Parameters:
- NUM_FIFOS, 5, number of FIFOs monitored.
- TH_W, 5, width of each threshold and occupancy field.
- IDLE_CYCLES, 4, consecutive all-empty cycles required in ACTIVE before returning to IDLE (>=1).

Ports (field i occupies bits [i*TH_W +: TH_W]):
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- init  in  1  configuration window request.
- cfg_low  in  NUM_FIFOS*TH_W  requested low thresholds.
- cfg_high  in  NUM_FIFOS*TH_W  requested high thresholds.
- occupancy  in  NUM_FIFOS*TH_W  live FIFO fill levels.
- empties  in  NUM_FIFOS  per-FIFO empty flags.
- errors  in  NUM_FIFOS  per-FIFO error flags.
- thr_low, thr_high  out  NUM_FIFOS*TH_W  latched thresholds.
- almost_empty, almost_full  out  NUM_FIFOS  registered watermark flags.
- err_capture  out  NUM_FIFOS  errors vector captured on entry to ERROR.
- cfg_err  out  1  threshold validation failure.
- idle_out, active_out, error_out  out  1  state status.
- state_out  out  5  one-hot state.

## Operation
States are one-hot: RESET=1, INIT=2, IDLE=4, ACTIVE=8, ERROR=16. An illegal encoding goes to RESET. Priority in every state: reset low > init > errors > empties.
- RESET: reset low forces state RESET. In RESET, all registers clear. On the first cycle with reset high, the next state is INIT.
- INIT: every cycle, thr_low<=cfg_low and thr_high<=cfg_high. When init is low, the FSM leaves INIT:
  - If any field has cfg_low > cfg_high, it goes to ERROR with cfg_err=1 and err_capture=0.
  - Otherwise it goes to IDLE.
- IDLE:
  - init high -> INIT.
  - Any errors bit set -> ERROR, with err_capture<=errors.
  - Not all empties set -> ACTIVE.
  - Otherwise it stays in IDLE.
- ACTIVE:
  - init high -> INIT.
  - Any errors bit set -> ERROR, with err_capture<=errors.
  - An idle counter increments on each cycle with empties all ones and clears otherwise. When the counter reaches IDLE_CYCLES-1 with empties still all ones, the FSM goes to IDLE.
  - The counter clears on entry to ACTIVE.
- ERROR: sticky; errors is ignored.
  - init high -> INIT; err_capture and cfg_err clear on that transition.
  - reset low -> RESET.
- Status outputs are a Moore decode of the state register: idle_out=(state==IDLE), active_out=(state==ACTIVE), error_out=(state==ERROR).
- Watermarks, registered: almost_full[i]<=(occupancy_i >= thr_high_i) and almost_empty[i]<=(occupancy_i <= thr_low_i). These are computed only while in IDLE or ACTIVE; otherwise they are 0.
- Comparisons are unsigned TH_W-bit. No arithmetic overflow is possible. The idle counter is $clog2(IDLE_CYCLES+1) bits and saturates.

## Timing
- Reset values: state=RESET, and every output is 0 except state_out=5'b00001.
- State transition latency: 1 cycle from the qualifying input to the state_out/status change.
- Thresholds: the thr_* values visible in IDLE are the cfg_* values sampled on the last INIT cycle, i.e. the cycle init is sampled low.
- Watermark flags lag occupancy by 1 cycle. They drop to 0 the cycle after leaving ACTIVE/IDLE.
- Return to IDLE: with empties all ones from the first ACTIVE cycle, IDLE is reached after exactly IDLE_CYCLES ACTIVE cycles.
- Simultaneous events:
  - errors together with the all-empty terminal count gives ERROR.
  - init together with errors gives INIT, and err_capture is unchanged.
- Reset low mid-operation: RESET on the next edge, with all outputs cleared in that cycle.

## Structure
- Shared package flow_ctrl_pkg holds:
  - State localparams (RESET_S..ERROR_S) and STATE_W=5.
  - A function field(vec,i) extracting a TH_W slice.
- Sub-module watermark_cmp (TH_W parameter) is instantiated NUM_FIFOS times via generate. It takes occupancy, thr_low, thr_high and enable, and produces the two registered flags. It has its own clk and reset.
- The FSM and idle counter live in flow_ctrl_fsm.

## Test plan
All scenarios use defaults (NUM_FIFOS=5, TH_W=5, IDLE_CYCLES=4).
1. Reset, then init high 3 cycles, with cfg_low=all 2 and cfg_high=all 20 -> state INIT, then IDLE. thr_low=5{2} and thr_high=5{20}; idle_out=1.
2. From IDLE, empties=5'h1E for 1 cycle and then 5'h1F -> ACTIVE for exactly 4 cycles, then IDLE. A 5'h1E pulse in the middle of the run restarts the count.
3. In ACTIVE, occupancy field0=20, then 2, then 10 -> one cycle later almost_full[0]=1, then almost_empty[0]=1, then both 0.
4. In ACTIVE, errors=5'b00100 for 1 cycle, then 0 -> ERROR persists, err_capture=5'b00100 and error_out=1. Then init=1 -> INIT with err_capture=0.
5. INIT with cfg_low field3=9 and cfg_high field3=4, then init low -> ERROR, cfg_err=1, err_capture=0.
6. reset low for 1 cycle in ACTIVE, with errors and init also high -> RESET with all outputs 0. The next cycle goes to INIT.

Source files
------------

// File: rtl/flow_ctrl_pkg.sv
// rtl/flow_ctrl_pkg.sv - shared state encodings and field helper for the flow-control FSM
//
// Holds the one-hot state encoding (RESET_S..ERROR_S, STATE_W) and
// field(), which extracts slice i of a packed per-FIFO vector.
package flow_ctrl_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] RESET_S  = 5'b00001;
    localparam logic [STATE_W-1:0] INIT_S   = 5'b00010;
    localparam logic [STATE_W-1:0] IDLE_S   = 5'b00100;
    localparam logic [STATE_W-1:0] ACTIVE_S = 5'b01000;
    localparam logic [STATE_W-1:0] ERROR_S  = 5'b10000;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = RESET_S,
        ST_INIT   = INIT_S,
        ST_IDLE   = IDLE_S,
        ST_ACTIVE = ACTIVE_S,
        ST_ERROR  = ERROR_S
    } state_e;

    // field() works on a widened copy of the packed vector so that a single
    // function serves every NUM_FIFOS/TH_W combination. Callers zero-extend
    // into FIELD_VEC_MAX bits and truncate the result back to TH_W.
    localparam int FIELD_W_MAX   = 32;
    localparam int FIELD_VEC_MAX = 1024;
    localparam int TH_W_DEF      = 5;

    function automatic logic [FIELD_W_MAX-1:0] field(
        input logic [FIELD_VEC_MAX-1:0] vec,
        input int unsigned              i,
        input int unsigned              w = TH_W_DEF
    );
        logic [FIELD_VEC_MAX-1:0] shifted;
        logic [FIELD_W_MAX-1:0]   mask;
        shifted = vec >> (i * w);
        mask    = (FIELD_W_MAX'(1) << w) - FIELD_W_MAX'(1);
        return FIELD_W_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/flow_ctrl_fsm_if.sv
// rtl/flow_ctrl_fsm_if.sv - configuration, FIFO status and flag bundle for flow_ctrl_fsm
//
// master: FIFO bank / system side (drives init, cfg_*, occupancy, empties,
//         errors; observes thresholds, flags and state).
// slave:  flow_ctrl_fsm.
interface flow_ctrl_fsm_if #(
    parameter int NUM_FIFOS = 5,
    parameter int TH_W      = 5
);
    import flow_ctrl_pkg::*;

    logic                      init;
    logic [NUM_FIFOS*TH_W-1:0] cfg_low;
    logic [NUM_FIFOS*TH_W-1:0] cfg_high;
    logic [NUM_FIFOS*TH_W-1:0] occupancy;
    logic [NUM_FIFOS-1:0]      empties;
    logic [NUM_FIFOS-1:0]      errors;

    logic [NUM_FIFOS*TH_W-1:0] thr_low;
    logic [NUM_FIFOS*TH_W-1:0] thr_high;
    logic [NUM_FIFOS-1:0]      almost_empty;
    logic [NUM_FIFOS-1:0]      almost_full;
    logic [NUM_FIFOS-1:0]      err_capture;
    logic                      cfg_err;
    logic                      idle_out;
    logic                      active_out;
    logic                      error_out;
    logic [STATE_W-1:0]        state_out;

    modport master (
        output init, cfg_low, cfg_high, occupancy, empties, errors,
        input  thr_low, thr_high, almost_empty, almost_full, err_capture,
               cfg_err, idle_out, active_out, error_out, state_out
    );

    modport slave (
        input  init, cfg_low, cfg_high, occupancy, empties, errors,
        output thr_low, thr_high, almost_empty, almost_full, err_capture,
               cfg_err, idle_out, active_out, error_out, state_out
    );
endinterface

// File: rtl/flow_ctrl_fsm_watermark_cmp.sv
// rtl/flow_ctrl_fsm_watermark_cmp.sv - registered almost-empty/almost-full flags for one FIFO
//
// Ports: clk, reset (sync, active-low), en, occupancy, thr_low, thr_high,
//        almost_empty, almost_full. Flags are forced to 0 while en is low.
module watermark_cmp #(
    parameter int TH_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [TH_W-1:0] occupancy,
    input  logic [TH_W-1:0] thr_low,
    input  logic [TH_W-1:0] thr_high,
    output logic            almost_empty,
    output logic            almost_full
);
    logic ae_d, ae_q;
    logic af_d, af_q;

    always_comb begin
        ae_d = en && (occupancy <= thr_low);
        af_d = en && (occupancy >= thr_high);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ae_q <= 1'b0;
            af_q <= 1'b0;
        end else begin
            ae_q <= ae_d;
            af_q <= af_d;
        end
    end

    assign almost_empty = ae_q;
    assign almost_full  = af_q;
endmodule

// File: rtl/flow_ctrl_fsm.sv
// rtl/flow_ctrl_fsm.sv - flow-control FSM: threshold init/validation, idle/active/error tracking, watermarks
//
// Ports: clk, reset (sync, active-low), bus (flow_ctrl_fsm_if.slave):
//   in  init, cfg_low, cfg_high, occupancy, empties, errors
//   out thr_low, thr_high, almost_empty, almost_full, err_capture, cfg_err,
//       idle_out, active_out, error_out, state_out (one-hot)
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS   = 5,
    parameter int TH_W        = 5,
    parameter int IDLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    flow_ctrl_fsm_if.slave  bus
);
    localparam int VEC_W = NUM_FIFOS * TH_W;
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e               state_d, state_q;
    logic [VEC_W-1:0]     thr_low_d, thr_low_q;
    logic [VEC_W-1:0]     thr_high_d, thr_high_q;
    logic [NUM_FIFOS-1:0] err_capture_d, err_capture_q;
    logic                 cfg_err_d, cfg_err_q;
    logic [CNT_W-1:0]     idle_cnt_d, idle_cnt_q;

    logic [FIELD_VEC_MAX-1:0] cfg_low_ext, cfg_high_ext;
    logic [FIELD_VEC_MAX-1:0] occ_ext, thr_low_ext, thr_high_ext;
    logic                     cfg_bad;
    logic                     all_empty;
    logic                     any_error;
    logic                     wm_en;

    assign cfg_low_ext  = FIELD_VEC_MAX'(bus.cfg_low);
    assign cfg_high_ext = FIELD_VEC_MAX'(bus.cfg_high);
    assign occ_ext      = FIELD_VEC_MAX'(bus.occupancy);
    assign thr_low_ext  = FIELD_VEC_MAX'(thr_low_q);
    assign thr_high_ext = FIELD_VEC_MAX'(thr_high_q);

    assign all_empty = &bus.empties;
    assign any_error = |bus.errors;

    always_comb begin
        cfg_bad = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (field(cfg_low_ext, i, TH_W) > field(cfg_high_ext, i, TH_W))
                cfg_bad = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        thr_low_d     = thr_low_q;
        thr_high_d    = thr_high_q;
        err_capture_d = err_capture_q;
        cfg_err_d     = cfg_err_q;
        idle_cnt_d    = idle_cnt_q;

        case (state_q)
            ST_RESET: begin
                thr_low_d     = '0;
                thr_high_d    = '0;
                err_capture_d = '0;
                cfg_err_d     = 1'b0;
                idle_cnt_d    = '0;
                state_d       = ST_INIT;
            end
            ST_INIT: begin
                // Thresholds track cfg_* for the whole window, so the values
                // held afterwards are those of the cycle init was seen low.
                thr_low_d  = bus.cfg_low;
                thr_high_d = bus.cfg_high;
                if (!bus.init) begin
                    if (cfg_bad) begin
                        state_d       = ST_ERROR;
                        cfg_err_d     = 1'b1;
                        err_capture_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.init) begin
                    state_d = ST_INIT;
                end else if (any_error) begin
                    state_d       = ST_ERROR;
                    err_capture_d = bus.errors;
                end else if (!all_empty) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (bus.init) begin
                    state_d = ST_INIT;
                end else if (any_error) begin
                    state_d       = ST_ERROR;
                    err_capture_d = bus.errors;
                end else if (all_empty) begin
                    if (idle_cnt_q == CNT_TERM)
                        state_d = ST_IDLE;
                    else if (idle_cnt_q != CNT_MAX)
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                if (bus.init) begin
                    state_d       = ST_INIT;
                    err_capture_d = '0;
                    cfg_err_d     = 1'b0;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RESET;
            thr_low_q     <= '0;
            thr_high_q    <= '0;
            err_capture_q <= '0;
            cfg_err_q     <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            thr_low_q     <= thr_low_d;
            thr_high_q    <= thr_high_d;
            err_capture_q <= err_capture_d;
            cfg_err_q     <= cfg_err_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign wm_en = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_wm
        watermark_cmp #(.TH_W(TH_W)) u_wm (
            .clk          (clk),
            .reset        (reset),
            .en           (wm_en),
            .occupancy    (TH_W'(field(occ_ext, g, TH_W))),
            .thr_low      (TH_W'(field(thr_low_ext, g, TH_W))),
            .thr_high     (TH_W'(field(thr_high_ext, g, TH_W))),
            .almost_empty (bus.almost_empty[g]),
            .almost_full  (bus.almost_full[g])
        );
    end

    assign bus.thr_low     = thr_low_q;
    assign bus.thr_high    = thr_high_q;
    assign bus.err_capture = err_capture_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.state_out   = state_q;
    assign bus.idle_out    = (state_q == ST_IDLE);
    assign bus.active_out  = (state_q == ST_ACTIVE);
    assign bus.error_out   = (state_q == ST_ERROR);
endmodule
